// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two circular line buffers feed a 2-column shift register, emitting raster-order windows.
// Define CONV_WINDOW_ZERO_PAD_EN for same-size (zero padded) output; default build emits valid-only windows.
module conv_window_gen #(
  parameter int DATA_BIT = 9,
  parameter int IMG_W    = 224,
  parameter int IMG_H    = 224,
  parameter int CNT_BIT  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_BIT-1:0] in_pixel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [9*DATA_BIT-1:0]      matrix_out,
  output logic [CNT_BIT-1:0]         out_row,
  output logic [CNT_BIT-1:0]         out_col,
  output logic                       frame_done
);

`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_BIT-1:0] COL_LAST  = CNT_BIT'(IMG_W - 1);
  localparam logic [CNT_BIT-1:0] ROW_LAST  = CNT_BIT'(IMG_H - 1);
  localparam logic [CNT_BIT-1:0] EDGE_LAST = CNT_BIT'(IMG_H - 2);
  localparam logic [CNT_BIT-1:0] WIN_LO    = PAD_EN ? '0 : CNT_BIT'(1);
  localparam logic [CNT_BIT-1:0] WCOL_HI   = PAD_EN ? COL_LAST : CNT_BIT'(IMG_W - 2);
  localparam logic [CNT_BIT-1:0] WROW_HI   = PAD_EN ? ROW_LAST : CNT_BIT'(IMG_H - 2);
  localparam logic [CNT_BIT-1:0] EN_LO     = PAD_EN ? CNT_BIT'(1) : CNT_BIT'(2);
  localparam logic [CNT_BIT-1:0] FILL_COL  = PAD_EN ? '0 : CNT_BIT'(1);
  localparam logic [CNT_BIT:0]   FL_LIM    = (CNT_BIT+1)'(IMG_W);

  typedef enum logic [2:0] {IDLE, FILL, RUN, EDGE, FLUSH} state_t;
  state_t state_reg, state_next;

  logic [CNT_BIT-1:0] in_row_reg, in_col_reg, win_row_reg, win_col_reg, in_col_next;
  logic [DATA_BIT-1:0] lb0_mem [IMG_W];
  logic [DATA_BIT-1:0] lb1_mem [IMG_W];
  logic [DATA_BIT-1:0] rd0_reg, rd1_reg;
  logic [DATA_BIT-1:0] col_a_reg [3];
  logic [DATA_BIT-1:0] col_b_reg [3];
  logic [DATA_BIT-1:0] new_col [3];
  logic [AW-1:0]       rd_addr;
  logic [CNT_BIT:0]    flush_addr;
  logic [9*DATA_BIT-1:0] win_flat;
  logic out_free, accept, gen, shift, out_last_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  state_next = FILL;
      FILL:  if (accept && in_row_reg == EN_LO && in_col_reg == FILL_COL) state_next = RUN;
      RUN:   if (accept && in_col_reg == COL_LAST) begin
               if (PAD_EN)                     state_next = EDGE;
               else if (in_row_reg == ROW_LAST) state_next = FILL;
             end
      EDGE:  if (gen) state_next = (win_row_reg == EDGE_LAST) ? FLUSH : RUN;
      FLUSH: if (gen && win_col_reg == COL_LAST) state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  // Windows are generated in the same cycle the enabling column arrives; EDGE/FLUSH substitute line-buffer reads for the pixel.
  always_comb begin
    out_free   = !out_valid || out_ready;
    in_ready   = 1'b0;
    gen        = 1'b0;
    new_col[0] = rd1_reg;
    new_col[1] = rd0_reg;
    new_col[2] = in_pixel;
    case (state_reg)
      FILL:        in_ready = 1'b1;
      RUN:   begin
               in_ready = out_free;
               gen      = in_valid && out_free && (in_col_reg >= EN_LO);
             end
      EDGE, FLUSH: gen = out_free;
      default: ;
    endcase
    accept      = in_valid && in_ready;
    shift       = accept || (gen && (state_reg == EDGE || state_reg == FLUSH));
    in_col_next = accept ? ((in_col_reg == COL_LAST) ? '0 : in_col_reg + 1'b1) : in_col_reg;
    flush_addr  = {1'b0, win_col_reg} + (gen ? (CNT_BIT+1)'(2) : (CNT_BIT+1)'(1));
    case (state_reg)
      EDGE:    rd_addr = (gen && win_row_reg == EDGE_LAST) ? AW'(1) : '0;
      FLUSH:   rd_addr = (flush_addr >= FL_LIM) ? '0 : AW'(flush_addr);
      default: rd_addr = AW'(in_col_next);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_row_reg  <= '0;
      in_col_reg  <= '0;
      win_row_reg <= WIN_LO;
      win_col_reg <= WIN_LO;
    end else begin
      if (accept) begin
        in_col_reg <= in_col_next;
        if (in_col_reg == COL_LAST)
          in_row_reg <= (in_row_reg == ROW_LAST) ? '0 : in_row_reg + 1'b1;
      end
      if (gen) begin
        win_col_reg <= (win_col_reg == WCOL_HI) ? WIN_LO : win_col_reg + 1'b1;
        if (win_col_reg == WCOL_HI)
          win_row_reg <= (win_row_reg == WROW_HI) ? WIN_LO : win_row_reg + 1'b1;
      end
    end
  end

  // Read address is the column needed next cycle, so the registered read lines up with the arriving pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[in_col_reg[AW-1:0]] <= in_pixel;
      lb1_mem[in_col_reg[AW-1:0]] <= rd0_reg;
    end
    rd0_reg <= lb0_mem[rd_addr];
    rd1_reg <= lb1_mem[rd_addr];
    if (shift) begin
      col_a_reg <= col_b_reg;
      col_b_reg <= new_col;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_elem
      localparam int WR = gi / 3;
      localparam int WC = gi % 3;
      logic [DATA_BIT-1:0] elem;
      logic                pad_zero;
      assign elem = (WC == 0) ? col_a_reg[WR] : (WC == 1) ? col_b_reg[WR] : new_col[WR];
      assign pad_zero = PAD_EN && (((WR == 0) && (win_row_reg == '0)) ||
                                   ((WR == 2) && (win_row_reg == ROW_LAST)) ||
                                   ((WC == 0) && (win_col_reg == '0)) ||
                                   ((WC == 2) && (win_col_reg == COL_LAST)));
      assign win_flat[gi*DATA_BIT +: DATA_BIT] = pad_zero ? '0 : elem;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      matrix_out   <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_last_reg <= 1'b0;
    end else if (gen) begin
      out_valid    <= 1'b1;
      matrix_out   <= win_flat;
      out_row      <= win_row_reg;
      out_col      <= win_col_reg;
      out_last_reg <= (win_row_reg == WROW_HI) && (win_col_reg == WCOL_HI);
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  assign frame_done = out_valid && out_ready && out_last_reg;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x3 frame; expected windows come from a per-frame neighbourhood model.
module tb_conv_window_gen;
  localparam int DB = 9;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CB = 3;
  localparam int MW = 9 * DB;

`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, frame_done;
  logic [DB-1:0] in_pixel = '0;
  logic [MW-1:0] matrix_out;
  logic [CB-1:0] out_row, out_col;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_BIT(DB), .IMG_W(W), .IMG_H(H), .CNT_BIT(CB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .matrix_out(matrix_out),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  typedef struct {
    logic [MW-1:0] m;
    int r;
    int c;
    bit last;
  } win_t;

  win_t expq[$];
  int errors = 0, checks = 0, fd_count = 0, ready_mode = 0;
  logic [MW-1:0] cap [H][W];
  bit prev_stall = 1'b0;
  logic [MW-1:0] prev_m;
  logic [CB-1:0] prev_r, prev_c;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] pack9(input int e[9]);
    logic [MW-1:0] m;
    for (int i = 0; i < 9; i++) m[i*DB +: DB] = DB'(e[i]);
    return m;
  endfunction

  // Expected windows for one frame: each element is the pixel at (r-1+wr, c-1+wc), or 0 outside the image.
  task automatic push_frame(input int first, input int inc);
    int pix [H][W];
    int e [9];
    int pr, pc;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r][c] = first + (r * W + c) * inc;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (PAD || (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2)) begin
          win_t w;
          for (int wr = 0; wr < 3; wr++)
            for (int wc = 0; wc < 3; wc++) begin
              pr = r - 1 + wr;
              pc = c - 1 + wc;
              e[3*wr+wc] = (pr >= 0 && pr < H && pc >= 0 && pc < W) ? pix[pr][pc] : 0;
            end
          w.m = pack9(e);
          w.r = r;
          w.c = c;
          w.last = 1'b0;
          expq.push_back(w);
        end
      end
    end
    expq[expq.size()-1].last = 1'b1;
  endtask

  task automatic send_pixel(input int v);
    int n = 0;
    bit rdy = 1'b0;
    in_valid = 1'b1;
    in_pixel = DB'(v);
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL in_accept: pixel %0d not accepted within 200 cycles", v);
    end
  endtask

  task automatic send_frame(input int first, input int inc, input int npix, input bit gaps, input bit push);
    if (push) push_frame(first, inc);
    for (int k = 0; k < npix; k++) begin
      send_pixel(first + k * inc);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain: %0d windows still pending, want 0", expq.size());
    end
  endtask

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: every transfer against the model queue, holds while stalled, frame_done each cycle.
  always @(negedge clk) begin
    win_t e;
    bit exp_fd;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", MW'(out_valid), MW'(1'b1));
        check("hold_matrix", matrix_out, prev_m);
        check("hold_pos", MW'({out_row, out_col}), MW'({prev_r, prev_c}));
      end
      exp_fd = 1'b0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_window: got window (%0d,%0d), want none", out_row, out_col);
        end else begin
          e = expq.pop_front();
          exp_fd = e.last;
          check("win_matrix", matrix_out, e.m);
          check("win_row", MW'(out_row), MW'(e.r));
          check("win_col", MW'(out_col), MW'(e.c));
          if (int'(out_row) < H && int'(out_col) < W) cap[out_row][out_col] = matrix_out;
        end
      end
      check("frame_done", MW'(frame_done), MW'(exp_fd));
      if (frame_done) fd_count++;
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_m = matrix_out;
    prev_r = out_row;
    prev_c = out_col;
  end

  task automatic check_frame_literals();
    if (PAD) begin
      check("lit_w00", cap[0][0], pack9('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
      check("lit_w11", cap[1][1], pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
      check("lit_w23", cap[2][3], pack9('{7, 8, 0, 11, 12, 0, 0, 0, 0}));
    end else begin
      check("lit_w11", cap[1][1], pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
      check("lit_w12", cap[1][2], pack9('{2, 3, 4, 6, 7, 8, 10, 11, 12}));
    end
  endtask

  task automatic clear_cap();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) cap[r][c] = '1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int fd0;
    clear_cap();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", MW'(in_ready), '0);
    check("rst_out_valid", MW'(out_valid), '0);
    check("rst_matrix", matrix_out, '0);
    check("rst_pos", MW'({out_row, out_col}), '0);
    check("rst_frame_done", MW'(frame_done), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", MW'(in_ready), '0);
    @(posedge clk);
    #1;

    // Plain frame 1..12, always ready
    ready_mode = 0;
    fd0 = fd_count;
    send_frame(1, 1, W * H, 1'b0, 1'b1);
    drain();
    check("s1_frame_done_count", MW'(fd_count - fd0), MW'(1));
    check_frame_literals();

    // Signed passthrough: every pixel -256
    clear_cap();
    send_frame(-256, 0, W * H, 1'b0, 1'b1);
    drain();
    check("s3_signed", cap[1][1], {9{9'h100}});

    // Back-pressure 1,0,0,1 with random input gaps
    clear_cap();
    ready_mode = 1;
    send_frame(1, 1, W * H, 1'b1, 1'b1);
    drain();
    check_frame_literals();

    // Abort after 6 pixels with output blocked, then a fresh frame
    ready_mode = 2;
    @(posedge clk);
    #1;
    send_frame(1, 1, 6, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", MW'(out_valid), '0);
    check("abort_in_ready", MW'(in_ready), '0);
    @(posedge clk);
    #1;
    clear_cap();
    ready_mode = 0;
    send_frame(1, 1, W * H, 1'b0, 1'b1);
    drain();
    check_frame_literals();

    // Back-to-back frames
    fd0 = fd_count;
    send_frame(1, 1, W * H, 1'b0, 1'b1);
    send_frame(101, 1, W * H, 1'b0, 1'b1);
    drain();
    check("s6_frame_done_count", MW'(fd_count - fd0), MW'(2));
    check("s6_w11", cap[1][1], pack9('{101, 102, 103, 105, 106, 107, 109, 110, 111}));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution PE.
- Accepts one signed feature-map pixel per handshake in raster order and buffers two image rows in line buffers.
- Emits each 3x3 neighbourhood as one packed 9-element bus, in exactly the layout the PE consumes on its matrix input.
- One frame is IMG_W x IMG_H pixels; frames run back-to-back.

Parameters:
- DATA_BIT, 9, signed pixel width (matches PE matrix element width).
- IMG_W, 224, pixels per row (>=3).
- IMG_H, 224, rows per frame (>=3).
- CNT_BIT, 8, width of the row/column counters; must satisfy 2^CNT_BIT >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept in_pixel this cycle
- in_pixel  in  DATA_BIT  signed input pixel, raster order
- out_valid  out  1  matrix_out/out_row/out_col valid
- out_ready  in  1  downstream accepts window
- matrix_out  out  9*DATA_BIT  window; element i at [i*DATA_BIT +: DATA_BIT], i = 3*wr + wc, wr/wc = 0..2 top-left first
- out_row  out  CNT_BIT  centre row of current window
- out_col  out  CNT_BIT  centre column of current window
- frame_done  out  1  one-cycle pulse when the last window of a frame transfers

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): every state is cleared on the rising clk edge where rst=1.
- Reset values:
  - in_ready=0, out_valid=0, matrix_out=0, out_row=0, out_col=0, frame_done=0.
  - Counters cleared, state=IDLE. Line-buffer contents need not be cleared; they are never read before being rewritten.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_valid, matrix_out, out_row and out_col hold stable.
- State machine:
  - IDLE -> FILL on the first cycle after reset.
  - FILL: accept pixels with in_ready=1 and no outputs, until the first window's inputs are present.
  - RUN: in_ready = !out_valid | out_ready, unless an internally pending window exists. Each accepted pixel may enable one window.
  - EDGE: a single extra cycle at end of row (padding mode only) with in_ready=0, used to emit the right-edge window.
  - FLUSH: after the last frame pixel is accepted, in_ready=0 and the remaining windows are emitted one per output transfer.
  - After the last window transfers: frame_done pulses, and the state returns to FILL for the next frame, with counters at 0.
- Window ordering: windows are emitted in raster order of centre (out_row, out_col).
- Latency:
  - Window (r,c) becomes out_valid exactly 1 cycle after acceptance of its enabling pixel (min(r+1,H-1), min(c+1,W-1)), given an empty output register.
  - When the window is produced in EDGE or FLUSH, it becomes valid 1 cycle after that state is entered.
- Arithmetic: pure data movement. Pixel bits are copied unchanged, signed, with no extension or rounding.
- Counters:
  - The input column counter wraps at IMG_W-1 and then increments the input row counter.
  - The row counter wraps at IMG_H-1 to 0.
- Line buffers: two IMG_W-deep rows, circular, indexed by the input column counter.
- Boundary rules:
  - in_valid held low mid-row: the block stalls with no state change.
  - Output back-pressure never drops or duplicates a window.
  - rst asserted mid-frame: the partial frame is discarded, and the next accepted pixel is pixel (0,0).
  - out_ready=1 while out_valid=0 has no effect.

Optional Feature:
- Macro: CONV_WINDOW_ZERO_PAD_EN.
- Defined (same padding):
  - IMG_W*IMG_H windows per frame, centres (0..H-1, 0..W-1).
  - Out-of-image window elements are 0.
  - EDGE and FLUSH states are present.
- Undefined (valid only):
  - (IMG_W-2)*(IMG_H-2) windows per frame, centres r=1..H-2, c=1..W-2.
  - No EDGE or FLUSH states; the window for centre (r,c) is enabled by pixel (r+1,c+1) only.
  - frame_done pulses on the transfer of window (H-2, W-2).

Test Plan:
1. Padding on, IMG_W=4, IMG_H=3, pixels 1..12, out_ready=1 -> 12 windows. Window (0,0) elements = 0,0,0,0,1,2,0,5,6. Window (1,1) = 1,2,3,5,6,7,9,10,11. Window (2,3) = 7,8,0,11,12,0,0,0,0. frame_done on the 12th transfer.
2. Padding off, same frame -> exactly 2 windows. (1,1) = 1,2,3,5,6,7,9,10,11 and (1,2) = 2,3,4,6,7,8,10,11,12. frame_done with the second window.
3. Signed passthrough: frame of all -256 (0x100), padding off -> every matrix_out element is 9'h100, with no sign corruption.
4. Back-pressure: out_ready toggled 1,0,0,1 repeating, random in_valid gaps -> window sequence and values identical to scenario 1, and outputs stable while stalled.
5. Reset mid-frame: rst for 1 cycle after 6 pixels, then a fresh 1..12 frame -> outputs identical to scenario 1, with nothing from the aborted frame.
6. Back-to-back frames: two 4x3 frames (1..12 then 101..112) with no gap -> second frame's window (1,1) = 101,102,103,105,106,107,109,110,111, and two frame_done pulses.
